// File: rtl/tcm_mem_loader_if.sv
// rtl/tcm_mem_loader_if.sv - command, response and TCM port bundle for tcm_mem_loader
interface tcm_mem_loader_if;
  logic        cmd_valid_i;
  logic        cmd_accept_o;
  logic [1:0]  cmd_op_i;
  logic [16:0] cmd_addr_i;
  logic [31:0] cmd_data_i;
  logic [3:0]  cmd_mask_i;
  logic [15:0] cmd_len_i;
  logic        resp_valid_o;
  logic        resp_accept_i;
  logic [31:0] resp_data_o;
  logic        resp_error_o;
  logic [13:0] tcm_addr_o;
  logic [63:0] tcm_data_o;
  logic [7:0]  tcm_wr_o;
  logic [63:0] tcm_data_i;

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, cmd_mask_i, cmd_len_i,
    input  resp_accept_i, tcm_data_i,
    output cmd_accept_o, resp_valid_o, resp_data_o, resp_error_o,
    output tcm_addr_o, tcm_data_o, tcm_wr_o
  );

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, cmd_mask_i, cmd_len_i,
    output resp_accept_i, tcm_data_i,
    input  cmd_accept_o, resp_valid_o, resp_data_o, resp_error_o,
    input  tcm_addr_o, tcm_data_o, tcm_wr_o
  );
endinterface

// File: rtl/tcm_mem_loader.sv
// rtl/tcm_mem_loader.sv - 32-bit word read/write/fill command initiator for a 64-bit TCM port
module tcm_mem_loader (
  input  logic            clk_i,
  input  logic            rst_i,
  tcm_mem_loader_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_FILL, S_RESP} state_t;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_FILL  = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  state_t      state, state_n;
  logic [16:0] addr_q, addr_n;
  logic [31:0] data_q, data_n;
  logic [15:0] cnt_q, cnt_n;
  logic        accept_n, resp_valid_n, resp_error_n;
  logic [31:0] resp_data_n;
  logic [13:0] tcm_addr_n;
  logic [63:0] tcm_data_n;
  logic [7:0]  tcm_wr_n;

  logic        handshake, cmd_err;
  logic [18:0] fill_end;
  logic [16:0] fill_addr_next;
  logic [31:0] fill_data_next;

  function automatic logic [7:0] lanes(input logic hi, input logic [3:0] be);
    return hi ? {be, 4'h0} : {4'h0, be};
  endfunction

  assign handshake      = bus.cmd_valid_i & bus.cmd_accept_o;
  // Extra headroom bit so a large length can never wrap back into range
  assign fill_end       = {2'b00, bus.cmd_addr_i} + {1'b0, bus.cmd_len_i, 2'b00};
  assign cmd_err        = (bus.cmd_addr_i[1:0] != 2'b00) || (bus.cmd_op_i == OP_RSVD) ||
                          ((bus.cmd_op_i == OP_FILL) && (fill_end > 19'h20000));
  assign fill_addr_next = addr_q + 17'd4;
  assign fill_data_next = data_q + 32'd1;

  always_comb begin
    state_n      = state;
    addr_n       = addr_q;
    data_n       = data_q;
    cnt_n        = cnt_q;
    accept_n     = 1'b0;
    resp_valid_n = bus.resp_valid_o;
    resp_error_n = bus.resp_error_o;
    resp_data_n  = bus.resp_data_o;
    tcm_addr_n   = bus.tcm_addr_o;
    tcm_data_n   = bus.tcm_data_o;
    tcm_wr_n     = 8'h00;

    case (state)
      S_IDLE: begin
        accept_n = 1'b1;
        if (handshake) begin
          accept_n     = 1'b0;
          addr_n       = bus.cmd_addr_i;
          data_n       = bus.cmd_data_i;
          cnt_n        = bus.cmd_len_i;
          resp_data_n  = 32'h0;
          resp_error_n = cmd_err;
          tcm_addr_n   = bus.cmd_addr_i[16:3];
          tcm_data_n   = {bus.cmd_data_i, bus.cmd_data_i};
          if (cmd_err) begin
            state_n      = S_RESP;
            resp_valid_n = 1'b1;
          end else begin
            case (bus.cmd_op_i)
              OP_WRITE: begin
                state_n  = S_WRITE;
                tcm_wr_n = lanes(bus.cmd_addr_i[2], bus.cmd_mask_i);
              end
              OP_READ: state_n = S_READ;
              OP_FILL: begin
                if (bus.cmd_len_i == 16'd0) begin
                  state_n      = S_RESP;
                  resp_valid_n = 1'b1;
                end else begin
                  state_n  = S_FILL;
                  tcm_wr_n = lanes(bus.cmd_addr_i[2], 4'hF);
                end
              end
              default: begin
                state_n      = S_RESP;
                resp_valid_n = 1'b1;
              end
            endcase
          end
        end
      end
      S_WRITE: begin
        state_n      = S_RESP;
        resp_valid_n = 1'b1;
      end
      S_READ: begin
        resp_data_n  = addr_q[2] ? bus.tcm_data_i[63:32] : bus.tcm_data_i[31:0];
        state_n      = S_RESP;
        resp_valid_n = 1'b1;
      end
      S_FILL: begin
        // Outputs for the current word are already on the port; stage the next one
        if (cnt_q == 16'd1) begin
          state_n      = S_RESP;
          resp_valid_n = 1'b1;
        end else begin
          cnt_n      = cnt_q - 16'd1;
          addr_n     = fill_addr_next;
          data_n     = fill_data_next;
          tcm_addr_n = fill_addr_next[16:3];
          tcm_data_n = {fill_data_next, fill_data_next};
          tcm_wr_n   = lanes(fill_addr_next[2], 4'hF);
        end
      end
      S_RESP: begin
        if (bus.resp_accept_i) begin
          state_n      = S_IDLE;
          resp_valid_n = 1'b0;
          accept_n     = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state            <= S_IDLE;
      addr_q           <= '0;
      data_q           <= '0;
      cnt_q            <= '0;
      bus.cmd_accept_o <= 1'b0;
      bus.resp_valid_o <= 1'b0;
      bus.resp_error_o <= 1'b0;
      bus.resp_data_o  <= '0;
      bus.tcm_addr_o   <= '0;
      bus.tcm_data_o   <= '0;
      bus.tcm_wr_o     <= '0;
    end else begin
      state            <= state_n;
      addr_q           <= addr_n;
      data_q           <= data_n;
      cnt_q            <= cnt_n;
      bus.cmd_accept_o <= accept_n;
      bus.resp_valid_o <= resp_valid_n;
      bus.resp_error_o <= resp_error_n;
      bus.resp_data_o  <= resp_data_n;
      bus.tcm_addr_o   <= tcm_addr_n;
      bus.tcm_data_o   <= tcm_data_n;
      bus.tcm_wr_o     <= tcm_wr_n;
    end
  end
endmodule

// File: tb/tb_tcm_mem_loader.sv
// tb/tb_tcm_mem_loader.sv - self-checking bench for tcm_mem_loader
module tb_tcm_mem_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tcm_mem_loader_if bus();
  tcm_mem_loader dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [63:0] ram [16384];
  logic        ram_clr = 1'b1;
  int unsigned refm [32768];

  typedef struct {
    int          cyc;
    logic [13:0] a;
    logic [7:0]  wr;
  } wr_rec_t;
  wr_rec_t trace[$];

  typedef struct {
    logic [1:0]  op;
    logic [16:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [15:0] len;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_nwr;
    logic [21:0] exp_first;
  } vec_t;
  vec_t vecs[15];

  assign bus.tcm_data_i = ram[bus.tcm_addr_o];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_clr) begin
      for (int i = 0; i < 16384; i++) ram[i] <= 64'h0;
    end else begin
      for (int b = 0; b < 8; b++)
        if (bus.tcm_wr_o[b]) ram[bus.tcm_addr_o][8*b +: 8] <= bus.tcm_data_o[8*b +: 8];
    end
  end

  always @(negedge clk)
    if (bus.tcm_wr_o != 8'h00) trace.push_back('{cyc, bus.tcm_addr_o, bus.tcm_wr_o});

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Word-granular view of memory: plain array of 32-bit words indexed by byte address / 4
  task automatic model(input logic [1:0] op, input int addr, input logic [31:0] data,
                       input logic [3:0] mask, input int len,
                       output logic [31:0] edata, output logic eerr, output int elat, output int enwr);
    edata = 32'h0;
    enwr  = 0;
    eerr  = (addr % 4 != 0) || (op == 2'd3) || (op == 2'd2 && addr + 4 * len > 131072);
    elat  = 1;
    if (!eerr) begin
      case (op)
        2'd0: begin
          for (int b = 0; b < 4; b++)
            if (mask[b]) refm[addr / 4][8*b +: 8] = data[8*b +: 8];
          elat = 2;
          enwr = (mask != 4'h0) ? 1 : 0;
        end
        2'd1: begin
          edata = refm[addr / 4];
          elat  = 2;
        end
        default: begin
          for (int i = 0; i < len; i++) refm[addr / 4 + i] = data + i;
          elat = (len == 0) ? 1 : len + 1;
          enwr = len;
        end
      endcase
    end
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic [16:0] addr, input logic [31:0] data,
                           input logic [3:0] mask, input logic [15:0] len);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = op;
    bus.cmd_addr_i  = addr;
    bus.cmd_data_i  = data;
    bus.cmd_mask_i  = mask;
    bus.cmd_len_i   = len;
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [16:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input logic [15:0] len,
                        output logic [31:0] rdata, output logic rerr, output int lat);
    int guard;
    @(negedge clk);
    drive_cmd(op, addr, data, mask, len);
    guard = 0;
    while (bus.cmd_accept_o !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("accept_timeout", guard, 0);
    trace.delete();
    @(posedge clk);
    #1 bus.cmd_valid_i = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.resp_valid_o !== 1'b1 && lat < 100);
    rdata = bus.resp_data_o;
    rerr  = bus.resp_error_o;
    bus.resp_accept_i = 1'b1;
    @(posedge clk);
    #1 bus.resp_accept_i = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, md;
    logic        er, me;
    int          lat, ml, mn;
    logic [7:0]  fill_wr[5];
    logic [13:0] fill_a[5];
    logic [31:0] hold_data;

    vecs[0]  = '{2'd0, 17'h00104, 32'hA5A51234, 4'b0101, 16'd0, 32'h0,        1'b0, 2, 1, {14'h0020, 8'h50}};
    vecs[1]  = '{2'd1, 17'h00104, 32'h0,        4'h0,    16'd0, 32'h00A50034, 1'b0, 2, 0, 22'h0};
    vecs[2]  = '{2'd2, 17'h00008, 32'hFFFFFFFE, 4'h0,    16'd5, 32'h0,        1'b0, 6, 5, {14'h0001, 8'h0F}};
    vecs[3]  = '{2'd1, 17'h00008, 32'h0,        4'h0,    16'd0, 32'hFFFFFFFE, 1'b0, 2, 0, 22'h0};
    vecs[4]  = '{2'd1, 17'h0000C, 32'h0,        4'h0,    16'd0, 32'hFFFFFFFF, 1'b0, 2, 0, 22'h0};
    vecs[5]  = '{2'd1, 17'h00010, 32'h0,        4'h0,    16'd0, 32'h00000000, 1'b0, 2, 0, 22'h0};
    vecs[6]  = '{2'd1, 17'h00014, 32'h0,        4'h0,    16'd0, 32'h00000001, 1'b0, 2, 0, 22'h0};
    vecs[7]  = '{2'd1, 17'h00018, 32'h0,        4'h0,    16'd0, 32'h00000002, 1'b0, 2, 0, 22'h0};
    vecs[8]  = '{2'd0, 17'h00002, 32'h12345678, 4'hF,    16'd0, 32'h0,        1'b1, 1, 0, 22'h0};
    vecs[9]  = '{2'd3, 17'h00040, 32'h12345678, 4'hF,    16'd4, 32'h0,        1'b1, 1, 0, 22'h0};
    vecs[10] = '{2'd2, 17'h1FFFC, 32'h0BADF00D, 4'h0,    16'd2, 32'h0,        1'b1, 1, 0, 22'h0};
    vecs[11] = '{2'd2, 17'h1FFFC, 32'hDEADBEEF, 4'h0,    16'd1, 32'h0,        1'b0, 2, 1, {14'h3FFF, 8'hF0}};
    vecs[12] = '{2'd1, 17'h1FFFC, 32'h0,        4'h0,    16'd0, 32'hDEADBEEF, 1'b0, 2, 0, 22'h0};
    vecs[13] = '{2'd2, 17'h00100, 32'h55555555, 4'h0,    16'd0, 32'h0,        1'b0, 1, 0, 22'h0};
    vecs[14] = '{2'd1, 17'h00003, 32'h0,        4'h0,    16'd0, 32'h0,        1'b1, 1, 0, 22'h0};

    for (int i = 0; i < 32768; i++) refm[i] = 0;
    bus.cmd_valid_i = 1'b0; bus.cmd_op_i = '0; bus.cmd_addr_i = '0; bus.cmd_data_i = '0;
    bus.cmd_mask_i = '0; bus.cmd_len_i = '0; bus.resp_accept_i = 1'b0;

    #1 check("reset_outputs", {bus.cmd_accept_o, bus.resp_valid_o, bus.resp_error_o, bus.resp_data_o,
                               bus.tcm_wr_o, bus.tcm_addr_o, bus.tcm_data_o}, 0);
    repeat (2) @(posedge clk);
    ram_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("accept_before_edge", bus.cmd_accept_o, 0);
    @(negedge clk);
    check("accept_after_release", bus.cmd_accept_o, 1);

    for (int i = 0; i < 15; i++) begin
      do_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].mask, vecs[i].len, rd, er, lat);
      model(vecs[i].op, int'(vecs[i].addr), vecs[i].data, vecs[i].mask, int'(vecs[i].len), md, me, ml, mn);
      check($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
      check($sformatf("vec%0d_err", i), er, vecs[i].exp_err);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_nwrites", i), trace.size(), vecs[i].exp_nwr);
      if (vecs[i].exp_nwr > 0)
        check($sformatf("vec%0d_first_write", i),
              (trace.size() > 0) ? {trace[0].a, trace[0].wr} : 22'h0, vecs[i].exp_first);
    end

    // Fill trace: lanes alternate with address bit 2, one write per consecutive cycle
    fill_wr = '{8'h0F, 8'hF0, 8'h0F, 8'hF0, 8'h0F};
    fill_a  = '{14'd1, 14'd1, 14'd2, 14'd2, 14'd3};
    do_cmd(2'd2, 17'h00008, 32'hFFFFFFFE, 4'h0, 16'd5, rd, er, lat);
    model(2'd2, 8, 32'hFFFFFFFE, 4'h0, 5, md, me, ml, mn);
    check("fill_trace_len", trace.size(), 5);
    for (int i = 0; i < 5 && i < trace.size(); i++)
      check($sformatf("fill_trace%0d", i), {trace[i].cyc - trace[0].cyc, trace[i].a, trace[i].wr},
            {i, fill_a[i], fill_wr[i]});

    // Backpressure with a second command held valid throughout
    @(negedge clk);
    drive_cmd(2'd1, 17'h00104, 32'h0, 4'h0, 16'd0);
    @(posedge clk);
    #1 drive_cmd(2'd0, 17'h00300, 32'h11223344, 4'hF, 16'd0);
    lat = 0;
    do begin @(negedge clk); lat++; end while (bus.resp_valid_o !== 1'b1 && lat < 20);
    hold_data = refm[17'h00104 / 4];
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_hold%0d", i), {bus.resp_valid_o, bus.resp_error_o, bus.cmd_accept_o, bus.resp_data_o},
            {1'b1, 1'b0, 1'b0, hold_data});
      @(negedge clk);
    end
    bus.resp_accept_i = 1'b1;
    @(posedge clk);
    #1 bus.resp_accept_i = 1'b0;
    @(negedge clk);
    check("bp_next_accept", bus.cmd_accept_o, 1);
    @(posedge clk);
    #1 bus.cmd_valid_i = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (bus.resp_valid_o !== 1'b1 && lat < 20);
    check("bp_next_latency", lat, 2);
    bus.resp_accept_i = 1'b1;
    @(posedge clk);
    #1 bus.resp_accept_i = 1'b0;
    model(2'd0, 17'h00300, 32'h11223344, 4'hF, 0, md, me, ml, mn);
    do_cmd(2'd1, 17'h00300, 32'h0, 4'h0, 16'd0, rd, er, lat);
    check("bp_readback", rd, 32'h11223344);

    // Reset in the middle of a long fill: two words committed, third aborted
    @(negedge clk);
    drive_cmd(2'd2, 17'h00800, 32'h00000100, 4'h0, 16'd20);
    @(posedge clk);
    #1 bus.cmd_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("midfill_reset_outputs", {bus.cmd_accept_o, bus.resp_valid_o, bus.resp_error_o, bus.resp_data_o,
                                       bus.tcm_wr_o, bus.tcm_addr_o, bus.tcm_data_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midfill_accept_after_release", {bus.cmd_accept_o, bus.resp_valid_o}, 2'b10);
    refm[17'h00800 / 4] = 32'h100;
    refm[17'h00804 / 4] = 32'h101;
    do_cmd(2'd1, 17'h00800, 32'h0, 4'h0, 16'd0, rd, er, lat);
    check("midfill_word0", rd, 32'h100);
    do_cmd(2'd1, 17'h00804, 32'h0, 4'h0, 16'd0, rd, er, lat);
    check("midfill_word1", rd, 32'h101);
    do_cmd(2'd1, 17'h00808, 32'h0, 4'h0, 16'd0, rd, er, lat);
    check("midfill_word2", rd, 32'h0);

    for (int n = 0; n < 60; n++) begin
      int r, a, l;
      logic [1:0] op;
      logic [31:0] d;
      logic [3:0] m;
      r  = $urandom_range(0, 9);
      op = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a  = $urandom_range(0, 255) * 4;
      if ($urandom_range(0, 7) == 0) a = 32'h1FFE0 + $urandom_range(0, 7) * 4;
      if ($urandom_range(0, 9) == 0) a = a + $urandom_range(1, 3);
      l  = $urandom_range(0, 10);
      d  = $urandom;
      m  = 4'($urandom_range(0, 15));
      do_cmd(op, 17'(a), d, m, 16'(l), rd, er, lat);
      model(op, a, d, m, l, md, me, ml, mn);
      check($sformatf("rnd%0d_data", n), rd, md);
      check($sformatf("rnd%0d_err", n), er, me);
      check($sformatf("rnd%0d_latency", n), lat, ml);
      check($sformatf("rnd%0d_nwrites", n), trace.size(), mn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
